// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA/debug port.
// CPU normally wins; a saturating wait counter hands the DMA a slot after MAX_WAIT blocked cycles.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_wr,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_be,
    output logic            cpu_gnt,
    output logic            cpu_rvalid,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    input  logic            dma_req,
    input  logic            dma_wr,
    input  logic [AW-1:0]   dma_addr,
    input  logic [DW-1:0]   dma_wdata,
    input  logic [DW/8-1:0] dma_be,
    output logic            dma_gnt,
    output logic            dma_rvalid,
    output logic [DW-1:0]   dma_rdata,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_dma_q, owner_dma_d;
    logic [WW-1:0]   dma_wait_q, dma_wait_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
    logic            pick_dma;
    logic            rd_done;

    assign pick_dma = dma_req && (!cpu_req || (dma_wait_q >= WW'(MAX_WAIT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_dma_q <= 1'b0;
            dma_wait_q  <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dma_q <= owner_dma_d;
            dma_wait_q  <= dma_wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Everything is gated by rst so the outputs read zero during the reset cycle itself.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dma_d = owner_dma_q;
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        rd_done     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        mem_req = 1'b1;
                        if (pick_dma) begin
                            dma_gnt   = 1'b1;
                            mem_wr    = dma_wr;
                            mem_addr  = dma_addr;
                            mem_wdata = dma_wdata;
                            mem_be    = dma_be;
                        end else begin
                            cpu_gnt   = 1'b1;
                            mem_wr    = cpu_wr;
                            mem_addr  = cpu_addr;
                            mem_wdata = cpu_wdata;
                            mem_be    = cpu_be;
                        end
                        if (!mem_wr) begin
                            state_d     = RD_WAIT;
                            cnt_d       = CW'(RD_LAT);
                            owner_dma_d = pick_dma;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        rd_done = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_rvalid  = rd_done && !owner_dma_q;
        dma_rvalid  = rd_done && owner_dma_q;
        cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dma_rdata_d = dma_rvalid ? mem_rdata : dma_rdata_q;
        cpu_rdata   = rst ? '0 : cpu_rdata_d;
        dma_rdata   = rst ? '0 : dma_rdata_d;
        if (!dma_req || dma_gnt) begin
            dma_wait_d = '0;
        end else if (dma_wait_q < WW'(MAX_WAIT)) begin
            dma_wait_d = dma_wait_q + 1'b1;
        end else begin
            dma_wait_d = dma_wait_q;
        end
        // Stall drops in the rvalid cycle so the MEM/WB register can capture cpu_rdata.
        cpu_stall = !rst && ((cpu_req && !cpu_gnt) ||
                             (state_q == RD_WAIT && !owner_dma_q && !cpu_rvalid));
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled memory model (read latency 2).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_be, dma_be;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] memArray [0:63];
    logic [31:0] rdPipe1, rdPipe2;

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte-enabled writes at the edge, reads appear two cycles after the strobe.
    always @(posedge clk) begin
        if (mem_req && mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) memArray[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        rdPipe1 <= (mem_req && !mem_wr) ? memArray[mem_addr[7:2]] : 32'h0;
        rdPipe2 <= rdPipe1;
    end
    assign mem_rdata = rdPipe2;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cReq, input logic cWr, input logic [31:0] cAddr,
                                 input logic [31:0] cData, input logic dReq, input logic dWr,
                                 input logic [31:0] dAddr, input logic [31:0] dData);
        cpu_req = cReq; cpu_wr = cWr; cpu_addr = cAddr; cpu_wdata = cData; cpu_be = 4'hF;
        dma_req = dReq; dma_wr = dWr; dma_addr = dAddr; dma_wdata = dData; dma_be = 4'hF;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) memArray[i] = 32'h0;
        rdPipe1 = 32'h0;
        rdPipe2 = 32'h0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
        checkOutput("reset mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("reset cpu_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("reset cpu_rdata", cpu_rdata, 32'h0);
        nextCycle();
        rst = 1'b0;

        // CPU write completes at grant
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        checkOutput("wr cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        checkOutput("wr mem_req", {31'b0, mem_req}, 32'h1);
        checkOutput("wr mem_wr", {31'b0, mem_wr}, 32'h1);
        checkOutput("wr mem_addr", mem_addr, 32'h10);
        checkOutput("wr mem_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("wr mem_be", {28'b0, mem_be}, 32'hF);
        checkOutput("wr cpu_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("wr cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);

        // CPU read, data two cycles after grant
        nextCycle();
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("rd gnt T", {31'b0, cpu_gnt}, 32'h1);
        checkOutput("rd mem_wr T", {31'b0, mem_wr}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd stall T+1", {31'b0, cpu_stall}, 32'h1);
        checkOutput("rd rvalid T+1", {31'b0, cpu_rvalid}, 32'h0);
        checkOutput("rd mem_req T+1", {31'b0, mem_req}, 32'h0);
        checkOutput("rd mem_addr T+1", mem_addr, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd rvalid T+2", {31'b0, cpu_rvalid}, 32'h1);
        checkOutput("rd rdata T+2", cpu_rdata, 32'hDEADBEEF);
        checkOutput("rd stall T+2", {31'b0, cpu_stall}, 32'h0);
        checkOutput("rd dma_rvalid T+2", {31'b0, dma_rvalid}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd rvalid T+3", {31'b0, cpu_rvalid}, 32'h0);
        checkOutput("rd rdata hold", cpu_rdata, 32'hDEADBEEF);

        // Both write every cycle: CPU wins four, DMA wins the fifth
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            applyStimulus(1, 1, 32'h40, 32'h11110000, 1, 1, 32'h44, 32'h22220000);
            checkOutput($sformatf("starve cpu_gnt %0d", i), {31'b0, cpu_gnt},
                        (i % 5 == 4) ? 32'h0 : 32'h1);
            checkOutput($sformatf("starve dma_gnt %0d", i), {31'b0, dma_gnt},
                        (i % 5 == 4) ? 32'h1 : 32'h0);
            checkOutput($sformatf("starve mem_addr %0d", i), mem_addr,
                        (i % 5 == 4) ? 32'h44 : 32'h40);
            checkOutput($sformatf("starve cpu_stall %0d", i), {31'b0, cpu_stall},
                        (i % 5 == 4) ? 32'h1 : 32'h0);
        end

        // DMA read, CPU arrives during the wait and is held off
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0);
        checkOutput("dma rd gnt", {31'b0, dma_gnt}, 32'h1);
        checkOutput("dma rd cpu_stall", {31'b0, cpu_stall}, 32'h0);
        nextCycle();
        applyStimulus(1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 0, 0);
        checkOutput("dma wait cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
        checkOutput("dma wait cpu_stall", {31'b0, cpu_stall}, 32'h1);
        nextCycle();
        applyStimulus(1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 0, 0);
        checkOutput("dma rvalid", {31'b0, dma_rvalid}, 32'h1);
        checkOutput("dma rdata", dma_rdata, 32'hDEADBEEF);
        checkOutput("dma done cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
        checkOutput("dma done cpu_stall", {31'b0, cpu_stall}, 32'h1);
        checkOutput("dma done cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        nextCycle();
        applyStimulus(1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 0, 0);
        checkOutput("after dma cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        checkOutput("after dma cpu_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("after dma mem_addr", mem_addr, 32'h20);

        // Reset in the middle of a CPU read
        nextCycle();
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("rst rd gnt", {31'b0, cpu_gnt}, 32'h1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst mid cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        checkOutput("rst mid cpu_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("rst mid mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst mid cpu_rdata", cpu_rdata, 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst after cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        checkOutput("rst after cpu_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("rst after cpu_rdata", cpu_rdata, 32'h0);
        nextCycle();
        applyStimulus(1, 1, 32'h30, 32'h12345678, 0, 0, 0, 0);
        checkOutput("rst next gnt", {31'b0, cpu_gnt}, 32'h1);
        checkOutput("rst next mem_wdata", mem_wdata, 32'h12345678);

        // Back-to-back CPU writes, one per cycle
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1, 1, 32'(4 * i), 32'hA0 + 32'(i), 0, 0, 0, 0);
            checkOutput($sformatf("b2b gnt %0d", i), {31'b0, cpu_gnt}, 32'h1);
            checkOutput($sformatf("b2b stall %0d", i), {31'b0, cpu_stall}, 32'h0);
            checkOutput($sformatf("b2b addr %0d", i), mem_addr, 32'(4 * i));
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle mem_req", {31'b0, mem_req}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
